// File: rtl/xilinx_rst_seq.sv
// xilinx_rst_seq: orders clock lock, DRAM reset/calibration and SoC/USB reset release
module xilinx_rst_seq #(
  parameter int CntWidth      = 24,
  parameter int LockCycles    = 1024,
  parameter int DramRstCycles = 256,
  parameter int CalibTimeout  = 10000000,
  parameter int SocHoldCycles = 64,
  parameter bit UseDram       = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clk_locked_i,
  input  logic       dram_calib_done_i,
  input  logic       vio_reset_i,
  input  logic [1:0] boot_mode_i,
  output logic       dram_rst_o,
  output logic       soc_rst_no,
  output logic       usb_rst_no,
  output logic [1:0] boot_mode_o,
  output logic       seq_done_o,
  output logic       calib_err_o,
  output logic [2:0] state_o
);
  typedef enum logic [2:0] {
    ASSERT     = 3'd0,
    WAIT_LOCK  = 3'd1,
    DRAM_RST   = 3'd2,
    WAIT_CALIB = 3'd3,
    SOC_HOLD   = 3'd4,
    RUN        = 3'd5,
    ERROR      = 3'd6
  } state_e;
  localparam logic [CntWidth-1:0] LOCK_END  = CntWidth'(LockCycles - 1);
  localparam logic [CntWidth-1:0] DRAM_END  = CntWidth'(DramRstCycles - 1);
  localparam logic [CntWidth-1:0] CALIB_END = CntWidth'(CalibTimeout - 1);
  localparam logic [CntWidth-1:0] HOLD_END  = CntWidth'(SocHoldCycles - 1);
  state_e state, nxt;
  logic [CntWidth-1:0] cnt;
  logic abort, cnt_clr;
  // next state; lock loss in WAIT_LOCK only restarts the lock count, everything else aborts
  always_comb begin
    nxt = state;
    abort = !clk_locked_i || vio_reset_i;
    case (state)
      ASSERT:     nxt = vio_reset_i ? ASSERT : WAIT_LOCK;
      WAIT_LOCK:  nxt = vio_reset_i ? ASSERT :
                        (clk_locked_i && cnt == LOCK_END) ? (UseDram ? DRAM_RST : SOC_HOLD) : WAIT_LOCK;
      DRAM_RST:   nxt = abort ? ASSERT : (cnt == DRAM_END) ? WAIT_CALIB : DRAM_RST;
      WAIT_CALIB: nxt = abort ? ASSERT : dram_calib_done_i ? SOC_HOLD :
                        (cnt == CALIB_END) ? ERROR : WAIT_CALIB;
      SOC_HOLD:   nxt = abort ? ASSERT : (cnt == HOLD_END) ? RUN : SOC_HOLD;
      RUN:        nxt = (abort || (UseDram && !dram_calib_done_i)) ? ASSERT : RUN;
      ERROR:      nxt = vio_reset_i ? ASSERT : ERROR;
      default:    nxt = ASSERT;
    endcase
    cnt_clr = (nxt != state) || !(state inside {WAIT_LOCK, DRAM_RST, WAIT_CALIB, SOC_HOLD}) ||
              (state == WAIT_LOCK && !clk_locked_i);
  end
  // state, counter and outputs registered from the next state so they move together
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= ASSERT;
      cnt         <= '0;
      dram_rst_o  <= 1'b1;
      soc_rst_no  <= 1'b0;
      usb_rst_no  <= 1'b0;
      boot_mode_o <= 2'b00;
      seq_done_o  <= 1'b0;
      calib_err_o <= 1'b0;
    end else begin
      state       <= nxt;
      cnt         <= cnt_clr ? '0 : cnt + CntWidth'(1);
      dram_rst_o  <= nxt inside {ASSERT, WAIT_LOCK, DRAM_RST};
      soc_rst_no  <= nxt == RUN;
      usb_rst_no  <= nxt == RUN;
      seq_done_o  <= nxt == RUN;
      boot_mode_o <= (state == SOC_HOLD && nxt == RUN) ? boot_mode_i : boot_mode_o;
      calib_err_o <= calib_err_o || (state == WAIT_CALIB && nxt == ERROR);
    end
  end
  assign state_o = state;
endmodule
